sr_bank: RTL and testbench

Parametrised bank of WIDTH clocked SR storage cells that replaces the discrete 2-input and 3-input SR latches. Each cell accepts a set/reset pair and a synchronous preset/clear pair. A compile-time mode decides what happens when S and R are both asserted. Each channel flags S=R violations with a sticky bit and can optionally count them. The bank sits between raw control strobes and downstream logic that needs clean, glitch-free held state.

---
 rtl/sr_pkg.sv | 26 ++
 rtl/sr_cell.sv | 88 ++++++++
 rtl/sr_bank.sv | 52 +++++
 tb/tb_sr_bank.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and helpers for the sr_bank SR storage cell bank.
// The optional violation counters are enabled by defining SR_VIOL_CNT_EN.
package sr_pkg;

    typedef enum logic [1:0] {
        SR_HOLD,
        SR_SET,
        SR_RESET,
        SR_TOGGLE
    } sr_mode_e;

    // Resolves the S=R=1 case for a given mode and current stored value.
    function automatic logic sr_next(input sr_mode_e mode, input logic q);
        logic nq;
        nq = q;
        case (mode)
            SR_HOLD:   nq = q;
            SR_SET:    nq = 1'b1;
            SR_RESET:  nq = 1'b0;
            SR_TOGGLE: nq = ~q;
            default:   nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked SR channel: q flop, S/R edge registers, sticky violation flag
// and, when SR_VIOL_CNT_EN is defined, a saturating violation counter.
module sr_cell
    import sr_pkg::*;
#(
    parameter sr_mode_e MODE  = SR_HOLD,
    parameter int       EDGE  = 0,
    parameter int       CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s,
    input  logic             r,
    input  logic             ps,
    input  logic             pr,
    input  logic             viol_clr,
    output logic             q,
    output logic             viol
`ifdef SR_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0] viol_cnt
`endif
);

    logic s_prev;
    logic r_prev;
    logic s_eff;
    logic r_eff;
    logic both;
    logic viol_now;
    logic q_next;

    assign s_eff    = (EDGE != 0) ? (s & ~s_prev) : s;
    assign r_eff    = (EDGE != 0) ? (r & ~r_prev) : r;
    assign both     = s_eff & r_eff;
    // An S=R clash still counts as a violation while ps/pr override q.
    assign viol_now = (pr & ps) | both;

    always_comb begin
        q_next = q;
        if (pr)
            q_next = 1'b0;
        else if (ps)
            q_next = 1'b1;
        else if (both)
            q_next = sr_next(MODE, q);
        else if (s_eff)
            q_next = 1'b1;
        else if (r_eff)
            q_next = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; every register here is reset, none is a memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= 1'b0;
            s_prev <= 1'b0;
            r_prev <= 1'b0;
            viol   <= 1'b0;
        end else begin
            q      <= q_next;
            s_prev <= s;
            r_prev <= r;
            if (viol_now)
                viol <= 1'b1;
            else if (viol_clr)
                viol <= 1'b0;
        end
    end

`ifdef SR_VIOL_CNT_EN
    logic [CNT_W-1:0] cnt;

    // A clear in the same cycle as a violation restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (viol_clr)
            cnt <= viol_now ? CNT_W'(1) : '0;
        else if (viol_now && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign viol_cnt = cnt;
`endif

endmodule

// File: rtl/sr_bank.sv
// Bank of WIDTH independent clocked SR cells with violation flags; per-channel
// saturating violation counters and the viol_cnt port exist only under SR_VIOL_CNT_EN.
module sr_bank
    import sr_pkg::*;
#(
    parameter int       WIDTH = 8,
    parameter sr_mode_e MODE  = SR_HOLD,
    parameter int       EDGE  = 0,
    parameter int       CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       s,
    input  logic [WIDTH-1:0]       r,
    input  logic [WIDTH-1:0]       ps,
    input  logic [WIDTH-1:0]       pr,
    input  logic                   viol_clr,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qb,
    output logic [WIDTH-1:0]       viol
`ifdef SR_VIOL_CNT_EN
    ,
    output logic [WIDTH*CNT_W-1:0] viol_cnt
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE  (MODE),
            .EDGE  (EDGE),
            .CNT_W (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .s        (s[i]),
            .r        (r[i]),
            .ps       (ps[i]),
            .pr       (pr[i]),
            .viol_clr (viol_clr),
            .q        (q[i]),
            .viol     (viol[i])
`ifdef SR_VIOL_CNT_EN
            ,
            .viol_cnt (viol_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

    // qb comes straight off the q flops so it can never skew against q.
    assign qb = ~q;

endmodule

// File: tb/tb_sr_bank.sv
// Self-checking bench for sr_bank: three instances (HOLD level, TOGGLE level,
// HOLD edge) share stimulus; counter checks run when SR_VIOL_CNT_EN is defined.
module tb_sr_bank;
    import sr_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0]    q;
        logic [W-1:0]    viol;
        logic [W*CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s, r, ps, pr;
    logic          viol_clr;
    logic [W-1:0]  q_h, qb_h, v_h;
    logic [W-1:0]  q_t, qb_t, v_t;
    logic [W-1:0]  q_e, qb_e, v_e;
`ifdef SR_VIOL_CNT_EN
    logic [W*CW-1:0] c_h, c_t, c_e;
`endif

    int n_pass  = 0;
    int n_total = 0;

    exp_t sb [$];

    // Reference model state, index 0 = hold/level, 1 = toggle/level, 2 = hold/edge.
    logic [W-1:0] mq [3];
    logic [W-1:0] mv [3];
    logic [W-1:0] msp, mrp;
    int           mcnt [3][W];

    always #5 clk = ~clk;

    sr_bank #(.WIDTH(W), .MODE(SR_HOLD), .EDGE(0), .CNT_W(CW)) dut_hold (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .ps(ps), .pr(pr),
        .viol_clr(viol_clr), .q(q_h), .qb(qb_h), .viol(v_h)
`ifdef SR_VIOL_CNT_EN
        , .viol_cnt(c_h)
`endif
    );

    sr_bank #(.WIDTH(W), .MODE(SR_TOGGLE), .EDGE(0), .CNT_W(CW)) dut_tog (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .ps(ps), .pr(pr),
        .viol_clr(viol_clr), .q(q_t), .qb(qb_t), .viol(v_t)
`ifdef SR_VIOL_CNT_EN
        , .viol_cnt(c_t)
`endif
    );

    sr_bank #(.WIDTH(W), .MODE(SR_HOLD), .EDGE(1), .CNT_W(CW)) dut_edge (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .ps(ps), .pr(pr),
        .viol_clr(viol_clr), .q(q_e), .qb(qb_e), .viol(v_e)
`ifdef SR_VIOL_CNT_EN
        , .viol_cnt(c_e)
`endif
    );

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = '0;
            mv[k] = '0;
            for (int ch = 0; ch < W; ch++) mcnt[k][ch] = 0;
        end
        msp = '0;
        mrp = '0;
    endtask

    task automatic model_step();
        logic se, re, v, qn;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < W; ch++) begin
                se = (k == 2) ? (s[ch] & ~msp[ch]) : s[ch];
                re = (k == 2) ? (r[ch] & ~mrp[ch]) : r[ch];
                v  = (pr[ch] & ps[ch]) | (se & re);
                qn = mq[k][ch];
                if (pr[ch])          qn = 1'b0;
                else if (ps[ch])     qn = 1'b1;
                else if (se && re)   qn = (k == 1) ? ~qn : qn;
                else if (se)         qn = 1'b1;
                else if (re)         qn = 1'b0;
                mq[k][ch] = qn;
                if (v)             mv[k][ch] = 1'b1;
                else if (viol_clr) mv[k][ch] = 1'b0;
                if (viol_clr)                    mcnt[k][ch] = v ? 1 : 0;
                else if (v && mcnt[k][ch] < 15)  mcnt[k][ch] = mcnt[k][ch] + 1;
            end
        end
        msp = s;
        mrp = r;
    endtask

    // Drives one cycle of stimulus at the falling edge and returns 1ns after the rising edge.
    task automatic apply(input logic [W-1:0] si, ri, psi, pri, input logic clri);
        @(negedge clk);
        s = si; r = ri; ps = psi; pr = pri; viol_clr = clri;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] s_during);
        @(negedge clk);
        s = s_during; r = '0; ps = '0; pr = '0; viol_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset('0);
        n_total++; if (q_h !== 8'h00) $display("FAIL reset_q got %h want 00", q_h); else n_pass++;
        n_total++; if (qb_h !== 8'hFF) $display("FAIL reset_qb got %h want ff", qb_h); else n_pass++;
        n_total++; if (v_e !== 8'h00) $display("FAIL reset_viol got %h want 00", v_e); else n_pass++;
        apply(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        apply(8'h00, 8'h00, 8'hF0, 8'hF0, 1'b0);
        n_total++; if (q_h !== 8'h0F) $display("FAIL pre_reset_q got %h want 0f", q_h); else n_pass++;
        n_total++; if (v_h !== 8'hF0) $display("FAIL pre_reset_viol got %h want f0", v_h); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (q_h !== 8'h00 || q_t !== 8'h00 || q_e !== 8'h00)
            $display("FAIL async_reset_q got %h/%h/%h want 00", q_h, q_t, q_e); else n_pass++;
        n_total++; if (qb_h !== 8'hFF) $display("FAIL async_reset_qb got %h want ff", qb_h); else n_pass++;
        n_total++; if (v_h !== 8'h00) $display("FAIL async_reset_viol got %h want 00", v_h); else n_pass++;
`ifdef SR_VIOL_CNT_EN
        n_total++; if (c_h !== '0) $display("FAIL async_reset_cnt got %h want 0", c_h); else n_pass++;
`endif
        model_reset();
        @(negedge clk);
        s = '0; r = '0; ps = '0; pr = '0; viol_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_level_hold();
        logic [1:0] sr_seq [4];
        logic       eq [4];
        logic       ev [4];
        exp_t       e;
        sr_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        eq     = '{1'b0, 1'b0, 1'b1, 1'b1};
        ev     = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset('0);
        for (int i = 0; i < 4; i++) begin
            e = '0;
            e.q[0] = eq[i];
            e.viol[0] = ev[i];
            sb.push_back(e);
            apply({7'b0, sr_seq[i][1]}, {7'b0, sr_seq[i][0]}, '0, '0, 1'b0);
            e = sb.pop_front();
            n_total++; if (q_h[0] !== e.q[0]) $display("FAIL level_q step %0d got %b want %b", i, q_h[0], e.q[0]); else n_pass++;
            n_total++; if (v_h[0] !== e.viol[0]) $display("FAIL level_viol step %0d got %b want %b", i, v_h[0], e.viol[0]); else n_pass++;
            n_total++; if (qb_h !== ~q_h) $display("FAIL level_qb step %0d got %h want %h", i, qb_h, ~q_h); else n_pass++;
        end
    endtask

    task automatic test_toggle();
        logic eq [3];
        exp_t e;
        eq = '{1'b1, 1'b0, 1'b1};
        do_reset('0);
        for (int i = 0; i < 3; i++) begin
            e = '0;
            e.q[0] = eq[i];
            e.viol[0] = 1'b1;
            sb.push_back(e);
            apply(8'h01, 8'h01, '0, '0, 1'b0);
            e = sb.pop_front();
            n_total++; if (q_t[0] !== e.q[0]) $display("FAIL toggle_q step %0d got %b want %b", i, q_t[0], e.q[0]); else n_pass++;
            n_total++; if (v_t[0] !== e.viol[0]) $display("FAIL toggle_viol step %0d got %b want %b", i, v_t[0], e.viol[0]); else n_pass++;
        end
        n_total++; if (q_h[0] !== 1'b0) $display("FAIL hold_mode_q got %b want 0", q_h[0]); else n_pass++;
    endtask

    task automatic test_priority();
        exp_t e;
        do_reset('0);
        e = '0; e.q[3] = 1'b0; e.viol = 8'h08;
        sb.push_back(e);
        apply(8'h08, 8'h00, 8'h08, 8'h08, 1'b0);
        e = sb.pop_front();
        n_total++; if (q_h[3] !== e.q[3]) $display("FAIL prio_pr_q got %b want %b", q_h[3], e.q[3]); else n_pass++;
        n_total++; if (v_h !== e.viol) $display("FAIL prio_pr_viol got %h want %h", v_h, e.viol); else n_pass++;
        e = '0; e.q[3] = 1'b1; e.viol = 8'h08;
        sb.push_back(e);
        apply(8'h00, 8'h08, 8'h08, 8'h00, 1'b0);
        e = sb.pop_front();
        n_total++; if (q_h[3] !== e.q[3]) $display("FAIL prio_ps_q got %b want %b", q_h[3], e.q[3]); else n_pass++;
        n_total++; if (v_h !== e.viol) $display("FAIL prio_ps_viol got %h want %h", v_h, e.viol); else n_pass++;
    endtask

    task automatic test_edge();
        exp_t e;
        do_reset('0);
        for (int i = 0; i < 5; i++) begin
            e = '0; e.q = 8'h01; e.viol = 8'h00;
            sb.push_back(e);
            apply(8'h01, 8'h00, '0, '0, 1'b0);
            e = sb.pop_front();
            n_total++; if (q_e !== e.q) $display("FAIL edge_s_q cycle %0d got %h want %h", i, q_e, e.q); else n_pass++;
            n_total++; if (v_e !== e.viol) $display("FAIL edge_s_viol cycle %0d got %h want %h", i, v_e, e.viol); else n_pass++;
        end
        // s still high with no edge while r pulses: only R is effective.
        e = '0; e.q = 8'h00;
        sb.push_back(e);
        apply(8'h01, 8'h01, '0, '0, 1'b0);
        e = sb.pop_front();
        n_total++; if (q_e !== e.q) $display("FAIL edge_r_q got %h want %h", q_e, e.q); else n_pass++;
        n_total++; if (v_e !== 8'h00) $display("FAIL edge_r_viol got %h want 00", v_e); else n_pass++;
        n_total++; if (q_h[0] !== 1'b1) $display("FAIL level_ref_q got %b want 1", q_h[0]); else n_pass++;
        apply(8'h00, 8'h00, '0, '0, 1'b0);
        n_total++; if (q_e !== 8'h00) $display("FAIL edge_idle_q got %h want 00", q_e); else n_pass++;
        // Input high across reset release yields one edge in the first active cycle.
        do_reset(8'h02);
        apply(8'h02, 8'h00, '0, '0, 1'b0);
        n_total++; if (q_e !== 8'h02) $display("FAIL edge_post_reset_q got %h want 02", q_e); else n_pass++;
    endtask

    task automatic test_counter();
        exp_t e;
        do_reset('0);
        for (int i = 0; i < 20; i++) begin
            e = '0;
            e.viol = 8'h24;
            e.cnt[2*CW +: CW] = CW'((i + 1 > 15) ? 15 : i + 1);
            e.cnt[5*CW +: CW] = e.cnt[2*CW +: CW];
            sb.push_back(e);
            apply(8'h24, 8'h24, '0, '0, 1'b0);
            e = sb.pop_front();
            n_total++; if (v_h !== e.viol) $display("FAIL cnt_viol cycle %0d got %h want %h", i, v_h, e.viol); else n_pass++;
`ifdef SR_VIOL_CNT_EN
            n_total++; if (c_h !== e.cnt) $display("FAIL cnt_value cycle %0d got %h want %h", i, c_h, e.cnt); else n_pass++;
`endif
        end
        e = '0; e.viol = 8'h04; e.cnt[2*CW +: CW] = CW'(1);
        sb.push_back(e);
        apply(8'h04, 8'h04, '0, '0, 1'b1);
        e = sb.pop_front();
        n_total++; if (v_h !== e.viol) $display("FAIL clr_viol got %h want %h", v_h, e.viol); else n_pass++;
`ifdef SR_VIOL_CNT_EN
        n_total++; if (c_h !== e.cnt) $display("FAIL clr_cnt got %h want %h", c_h, e.cnt); else n_pass++;
`endif
    endtask

    task automatic test_random();
        exp_t e;
        logic [W-1:0] aq, aqb, av;
        do_reset('0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            s        = W'($urandom);
            r        = W'($urandom);
            ps       = W'($urandom & $urandom & $urandom);
            pr       = W'($urandom & $urandom & $urandom);
            viol_clr = ($urandom_range(0, 7) == 0);
            model_step();
            for (int k = 0; k < 3; k++) begin
                e = '0;
                e.q = mq[k];
                e.viol = mv[k];
                for (int ch = 0; ch < W; ch++) e.cnt[ch*CW +: CW] = mcnt[k][ch][CW-1:0];
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                e = sb.pop_front();
                case (k)
                    0:       begin aq = q_h; aqb = qb_h; av = v_h; end
                    1:       begin aq = q_t; aqb = qb_t; av = v_t; end
                    default: begin aq = q_e; aqb = qb_e; av = v_e; end
                endcase
                n_total++; if (aq !== e.q) $display("FAIL rand_q inst %0d cycle %0d got %h want %h", k, i, aq, e.q); else n_pass++;
                n_total++; if (aqb !== ~e.q) $display("FAIL rand_qb inst %0d cycle %0d got %h want %h", k, i, aqb, ~e.q); else n_pass++;
                n_total++; if (av !== e.viol) $display("FAIL rand_viol inst %0d cycle %0d got %h want %h", k, i, av, e.viol); else n_pass++;
`ifdef SR_VIOL_CNT_EN
                if (k == 0) begin
                    n_total++; if (c_h !== e.cnt) $display("FAIL rand_cnt cycle %0d got %h want %h", i, c_h, e.cnt); else n_pass++;
                end else if (k == 2) begin
                    n_total++; if (c_e !== e.cnt) $display("FAIL rand_cnt_edge cycle %0d got %h want %h", i, c_e, e.cnt); else n_pass++;
                end
`endif
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s = '0; r = '0; ps = '0; pr = '0; viol_clr = 1'b0;
        model_reset();
        test_reset();
        test_level_hold();
        test_toggle();
        test_priority();
        test_edge();
        test_counter();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
